// File: rtl/freelist.sv
// Physical register free list: compacted multi-port allocation from a speculative head,
// commit-tracked head for one-cycle redirect recovery, and multi-port reclaim at the tail.
module freelist #(
    parameter int unsigned prnum = 64,
    parameter int unsigned rwd   = 2,
    parameter int unsigned cwd   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [rwd-1:0]                       alloc_req,
    input  logic                                 rename,
    output logic                                 alloc_ready,
    output logic [rwd-1:0][$clog2(prnum)-1:0]    alloc_prd,
    input  logic [cwd-1:0]                       cmt_alloc,
    input  logic [cwd-1:0]                       free_valid,
    input  logic [cwd-1:0][$clog2(prnum)-1:0]    free_prd,
    input  logic                                 redirect,
    output logic [$clog2(prnum):0]               free_count
);

    localparam int unsigned IW    = $clog2(prnum);
    localparam int unsigned PW    = IW + 1;
    localparam int unsigned NINIT = prnum - 32;
    localparam int unsigned RIW   = (rwd > 1) ? $clog2(rwd) : 1;
    localparam int unsigned CIW   = (cwd > 1) ? $clog2(cwd) : 1;

    logic [IW-1:0] list_q [prnum];
    logic [PW-1:0] spec_head_q, spec_head_d;
    logic [PW-1:0] cmt_head_q, cmt_head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [PW-1:0]          req_cnt;
    logic [PW-1:0]          cmt_cnt;
    logic [PW-1:0]          free_cnt;
    logic [IW-1:0]          rd_idx;
    logic [cwd-1:0]         wr_en;
    logic [cwd-1:0][IW-1:0] wr_idx;

    assign free_count  = tail_q - spec_head_q;
    assign alloc_ready = (free_count >= req_cnt);

    // Compacted allocation: slot i takes the entry after all lower requesting slots.
    always_comb begin
        req_cnt   = '0;
        rd_idx    = '0;
        alloc_prd = '0;
        for (int unsigned i = 0; i < rwd; i++) begin
            rd_idx = spec_head_q[IW-1:0] + req_cnt[IW-1:0];
            if (alloc_req[RIW'(i)]) begin
                alloc_prd[RIW'(i)] = list_q[rd_idx];
                req_cnt            = req_cnt + PW'(1);
            end
        end
    end

    // Zero prd frees are dropped; the rest are packed at the tail in slot order.
    always_comb begin
        wr_en    = '0;
        wr_idx   = '0;
        free_cnt = '0;
        cmt_cnt  = '0;
        for (int unsigned j = 0; j < cwd; j++) begin
            if (free_valid[CIW'(j)] && (free_prd[CIW'(j)] != '0)) begin
                wr_en[CIW'(j)]  = 1'b1;
                wr_idx[CIW'(j)] = tail_q[IW-1:0] + free_cnt[IW-1:0];
                free_cnt        = free_cnt + PW'(1);
            end
            if (cmt_alloc[CIW'(j)]) begin
                cmt_cnt = cmt_cnt + PW'(1);
            end
        end
    end

    always_comb begin
        cmt_head_d  = cmt_head_q + cmt_cnt;
        tail_d      = tail_q + free_cnt;
        spec_head_d = spec_head_q;
        if (redirect) begin
            spec_head_d = cmt_head_d;
        end else if (rename && alloc_ready) begin
            spec_head_d = spec_head_q + req_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= PW'(NINIT);
            for (int unsigned i = 0; i < prnum; i++) begin
                list_q[IW'(i)] <= (i < NINIT) ? IW'(32 + i) : '0;
            end
        end else begin
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
            for (int unsigned j = 0; j < cwd; j++) begin
                if (wr_en[CIW'(j)]) begin
                    list_q[wr_idx[CIW'(j)]] <= free_prd[CIW'(j)];
                end
            end
        end
    end

    // Pointer ordering and double-free sanity checks.
    always @(posedge clk) begin
        if (!rst) begin
            a_occupancy: assert (PW'(tail_q - cmt_head_q) <= PW'(prnum))
                else $error("freelist: tail runs more than prnum ahead of cmt_head");
            if (!redirect) begin
                a_cmt_order: assert (PW'(spec_head_d - cmt_head_d) <= PW'(prnum))
                    else $error("freelist: cmt_head passes spec_head");
            end
            for (int unsigned j = 0; j < cwd; j++) begin
                for (int unsigned n = 0; n < prnum; n++) begin
                    if (wr_en[CIW'(j)] && (PW'(n) < free_count)) begin
                        a_double_free: assert (list_q[spec_head_q[IW-1:0] + IW'(n)] != free_prd[CIW'(j)])
                            else $error("freelist: freed prd already on the free list");
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: directed corner cases, then randomized traffic against a queue-based model.
module tb_freelist;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       alloc_req;
    logic             rename;
    logic             alloc_ready;
    logic [1:0][5:0]  alloc_prd;
    logic [1:0]       cmt_alloc;
    logic [1:0]       free_valid;
    logic [1:0][5:0]  free_prd;
    logic             redirect;
    logic [6:0]       free_count;

    int checks   = 0;
    int failures = 0;

    // Model: free pool in hand-out order, in-flight allocations oldest first, held (mapped) regs.
    int free_q[$];
    int inflight[$];
    int held[$];

    always #5 clk = ~clk;

    freelist #(.prnum(64), .rwd(2), .cwd(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .rename     (rename),
        .alloc_ready(alloc_ready),
        .alloc_prd  (alloc_prd),
        .cmt_alloc  (cmt_alloc),
        .free_valid (free_valid),
        .free_prd   (free_prd),
        .redirect   (redirect),
        .free_count (free_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        free_q.delete();
        inflight.delete();
        held.delete();
        for (int i = 32; i < 64; i++) free_q.push_back(i);
        for (int i = 1; i < 32; i++) held.push_back(i);
    endtask

    task automatic check_outputs(input string tag);
        int n;
        int k;
        n = pc2(alloc_req);
        k = 0;
        chk($sformatf("%s.free_count", tag), 32'(free_count), 32'(free_q.size()));
        chk($sformatf("%s.alloc_ready", tag), 32'(alloc_ready), 32'(free_q.size() >= n));
        for (int i = 0; i < 2; i++) begin
            if (alloc_req[i]) begin
                if (k < free_q.size())
                    chk($sformatf("%s.alloc_prd%0d", tag, i), 32'(alloc_prd[i]), 32'(free_q[k]));
                k++;
            end else begin
                chk($sformatf("%s.alloc_prd%0d", tag, i), 32'(alloc_prd[i]), 32'd0);
            end
        end
    endtask

    // Applies the currently driven inputs to the model as one clock edge.
    task automatic model_step();
        int n;
        int c;
        int pend[$];
        if (rst) begin
            model_reset();
            return;
        end
        n = pc2(alloc_req);
        c = pc2(cmt_alloc);
        for (int j = 0; j < 2; j++) begin
            if (free_valid[j] && free_prd[j] != 6'd0) begin
                for (int h = 0; h < held.size(); h++) begin
                    if (held[h] == int'(free_prd[j])) begin
                        held.delete(h);
                        break;
                    end
                end
                pend.push_back(int'(free_prd[j]));
            end
        end
        for (int i = 0; i < c; i++) held.push_back(inflight.pop_front());
        if (redirect) begin
            for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i]);
            inflight.delete();
        end else if (rename && free_q.size() >= n) begin
            for (int i = 0; i < n; i++) inflight.push_back(free_q.pop_front());
        end
        foreach (pend[p]) free_q.push_back(pend[p]);
    endtask

    task automatic drive(input logic [1:0] req, input logic ren, input logic [1:0] cmt,
                         input logic [1:0] fv, input logic [5:0] fp1, input logic [5:0] fp0,
                         input logic redir, input logic r);
        alloc_req   = req;
        rename      = ren;
        cmt_alloc   = cmt;
        free_valid  = fv;
        free_prd[1] = fp1;
        free_prd[0] = fp0;
        redirect    = redir;
        rst         = r;
        #1;
    endtask

    task automatic tick(input string tag);
        check_outputs(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [1:0] req, input logic ren, input logic [1:0] cmt);
        drive(req, ren, cmt, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        tick(tag);
    endtask

    task automatic reset_dut();
        drive(2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
        tick("rst");
    endtask

    initial begin
        logic [1:0]      req;
        logic [1:0]      cmt;
        logic [1:0]      fv;
        logic [1:0][5:0] fp;
        int              cmax;
        int              cc;
        int              tmp[$];
        int              idx;

        alloc_req  = '0;
        rename     = 1'b0;
        cmt_alloc  = '0;
        free_valid = '0;
        free_prd   = '0;
        redirect   = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state and first dual allocation.
        drive(2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("reset.free_count", 32'(free_count), 32'd32);
        chk("reset.alloc_ready", 32'(alloc_ready), 32'd1);
        drive(2'b11, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("dual.prd1", 32'(alloc_prd[1]), 32'd33);
        chk("dual.prd0", 32'(alloc_prd[0]), 32'd32);
        tick("dual");
        drive(2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("dual.next_count", 32'(free_count), 32'd30);
        tick("dual_idle");

        // Sparse request compacts onto slot 1.
        reset_dut();
        drive(2'b10, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("sparse.prd1", 32'(alloc_prd[1]), 32'd32);
        chk("sparse.prd0", 32'(alloc_prd[0]), 32'd0);
        tick("sparse");
        drive(2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("sparse.next_count", 32'(free_count), 32'd31);
        tick("sparse_idle");

        // Nearly empty list: request for two must stall.
        reset_dut();
        repeat (15) cyc("fill", 2'b11, 1'b1, 2'b00);
        cyc("fill", 2'b01, 1'b1, 2'b00);
        drive(2'b11, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("low.free_count", 32'(free_count), 32'd1);
        chk("low.not_ready", 32'(alloc_ready), 32'd0);
        tick("low_stall");
        drive(2'b01, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("low.hold_count", 32'(free_count), 32'd1);
        chk("low.ready", 32'(alloc_ready), 32'd1);
        chk("low.prd0", 32'(alloc_prd[0]), 32'd63);
        tick("low_last");

        // Zero prd free dropped; freed reg is not visible the same cycle.
        reset_dut();
        drive(2'b00, 1'b0, 2'b00, 2'b11, 6'd0, 6'd5, 1'b0, 1'b0);
        chk("free.same_cycle", 32'(free_count), 32'd32);
        tick("free");
        drive(2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("free.next_count", 32'(free_count), 32'd33);
        tick("free_idle");
        repeat (16) cyc("drain", 2'b11, 1'b1, 2'b00);
        drive(2'b01, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("free.reuse", 32'(alloc_prd[0]), 32'd5);
        tick("free_reuse");

        // Redirect with a same-cycle commit.
        reset_dut();
        cyc("rd_alloc", 2'b11, 1'b1, 2'b00);
        cyc("rd_alloc", 2'b11, 1'b1, 2'b00);
        cyc("rd_cmt", 2'b00, 1'b0, 2'b01);
        drive(2'b11, 1'b1, 2'b01, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        tick("rd_flush");
        drive(2'b01, 1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("redirect.prd0", 32'(alloc_prd[0]), 32'd34);
        chk("redirect.count", 32'(free_count), 32'd30);
        tick("rd_next");

        // Randomized traffic with pointer wrap, redirects and occasional reset.
        reset_dut();
        for (int cyc_n = 0; cyc_n < 10000; cyc_n++) begin
            req  = 2'($urandom_range(0, 3));
            cmax = (inflight.size() < 2) ? inflight.size() : 2;
            cc   = int'($urandom_range(0, cmax));
            if (cc == 0)      cmt = 2'b00;
            else if (cc == 2) cmt = 2'b11;
            else              cmt = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            fv  = '0;
            fp  = '0;
            tmp = held;
            for (int j = 0; j < 2; j++) begin
                if (held.size() > 31 && tmp.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx   = int'($urandom_range(0, tmp.size() - 1));
                    fp[j] = 6'(tmp[idx]);
                    fv[j] = 1'b1;
                    tmp.delete(idx);
                end else if ($urandom_range(0, 15) == 0) begin
                    fv[j] = 1'b1;
                end
            end
            drive(req, ($urandom_range(0, 7) != 0), cmt, fv, fp[1], fp[0],
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 2999) == 0));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
